// File: rtl/clkdiv_pkg.sv
// Shared definitions for the multi-channel clock divider: channel-index width
// helper, divisor presets and the per-channel counter operation encoding.
package clkdiv_pkg;

   // Reference system clock the presets below are derived from.
   localparam int unsigned SYS_CLK_HZ = 100_000_000;

   // Divisors giving a clk_slow square wave of the named rate at SYS_CLK_HZ.
   // clk_slow toggles once per division period, so its period is 2*divisor.
   localparam int unsigned DIV_SLOW_1HZ   = SYS_CLK_HZ / (2 * 1);
   localparam int unsigned DIV_SLOW_1KHZ  = SYS_CLK_HZ / (2 * 1_000);
   localparam int unsigned DIV_SLOW_10KHZ = SYS_CLK_HZ / (2 * 10_000);

   // Operation a channel counter performs on the coming clock edge.
   typedef enum logic [1:0] {
      OP_STEP = 2'd0,  // mid-period, advance the counter
      OP_TERM = 2'd1,  // terminal count, emit tick and restart
      OP_HOLD = 2'd2,  // count enable low, freeze
      OP_HALT = 2'd3   // active divisor is zero, channel parked
   } cnt_op_e;

   // Width of a channel index; a single channel still needs a one-bit select.
   function automatic int chan_w(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active and pending divisor, tick strobe and
// 50%-duty slow clock. A new divisor is staged and only takes effect at a
// period boundary (or while the channel is idle), so no short period occurs.
module clk_div_chan
   import clkdiv_pkg::*;
#(
   parameter int          WIDTH       = 26,
   parameter int unsigned DEFAULT_DIV = DIV_SLOW_1HZ
) (
   input  logic             clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_sync_clear,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_val,
   output logic             o_pending,
   output logic             o_tick,
   output logic             o_clk_slow
);

   localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_div_act;
   logic [WIDTH-1:0] r_div_pend;
   logic             r_pend;
   logic             r_tick;
   logic             r_clk_slow;

   logic [WIDTH-1:0] w_last;
   logic             w_apply;
   cnt_op_e          w_op;

   // Classify the coming edge and decide whether a staged divisor may land on it.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no
      // path leaves it unassigned and no latch is inferred.
      w_last  = r_div_act - WIDTH'(1);
      w_op    = OP_STEP;
      w_apply = 1'b0;
      // Zero divisor is tested first, so the wrapped w_last is never used.
      if (r_div_act == '0) begin
         w_op = OP_HALT;
      end else if (!i_en) begin
         w_op = OP_HOLD;
      // >= rather than == so a divisor that shrank while the channel sat
      // disabled mid-period still terminates instead of running off the end.
      end else if (r_cnt >= w_last) begin
         w_op = OP_TERM;
      end
      w_apply = r_pend && (w_op != OP_STEP);
   end

   // Counter, tick strobe and slow clock.
   always_ff @(posedge clk or negedge i_rst_n) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!i_rst_n) begin
         r_cnt      <= '0;
         r_tick     <= 1'b0;
         r_clk_slow <= 1'b0;
      end else if (i_sync_clear) begin
         r_cnt      <= '0;
         r_tick     <= 1'b0;
         r_clk_slow <= 1'b0;
      end else begin
         case (w_op)
            OP_HALT: begin
               r_cnt  <= '0;
               r_tick <= 1'b0;
            end
            OP_HOLD: begin
               r_tick <= 1'b0;
            end
            OP_TERM: begin
               r_cnt      <= '0;
               r_tick     <= 1'b1;
               r_clk_slow <= ~r_clk_slow;
            end
            default: begin
               r_cnt  <= r_cnt + WIDTH'(1);
               r_tick <= 1'b0;
            end
         endcase
      end
   end

   // Divisor staging: writes park in r_div_pend and move to r_div_act at the
   // next safe point; sync_clear is itself a safe point.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_div_act  <= DIV_RST;
         r_div_pend <= '0;
         r_pend     <= 1'b0;
      end else if (i_sync_clear) begin
         // A write in the clear cycle bypasses staging and supersedes any
         // older pending value.
         if (i_wr_en) begin
            r_div_act <= i_wr_val;
         end else if (r_pend) begin
            r_div_act <= r_div_pend;
         end
         r_pend <= 1'b0;
      end else begin
         if (w_apply) begin
            r_div_act <= r_div_pend;
         end
         // A write landing on an apply edge lets the older value apply and
         // becomes the next pending value itself.
         if (i_wr_en) begin
            r_div_pend <= i_wr_val;
            r_pend     <= 1'b1;
         end else if (w_apply) begin
            r_pend <= 1'b0;
         end
      end
   end

   assign o_pending  = r_pend;
   assign o_tick     = r_tick;
   assign o_clk_slow = r_clk_slow;

endmodule

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock divider. Decodes the divisor write port
// into per-channel strobes and fans clock, reset and sync_clear out to
// CHANNELS independent clk_div_chan instances.
module clk_divider_multi
   import clkdiv_pkg::*;
#(
   parameter  int          WIDTH       = 26,
   parameter  int          CHANNELS    = 4,
   parameter  int unsigned DEFAULT_DIV = DIV_SLOW_1HZ,
   localparam int          CHAN_W      = chan_w(CHANNELS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] en,
   input  logic                sync_clear,
   input  logic                div_we,
   input  logic [CHAN_W-1:0]   div_sel,
   input  logic [WIDTH-1:0]    div_val,
   output logic [CHANNELS-1:0] div_pending,
   output logic [CHANNELS-1:0] tick,
   output logic [CHANNELS-1:0] clk_slow
);

   logic [CHANNELS-1:0] w_wr_en;

   // One-hot write strobe; a select beyond the last channel matches nothing.
   always_comb begin
      w_wr_en = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         w_wr_en[i] = div_we && (int'(div_sel) == i);
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      clk_div_chan #(
         .WIDTH       (WIDTH),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
         .clk          (clk),
         .i_rst_n      (reset),
         .i_en         (en[g]),
         .i_sync_clear (sync_clear),
         .i_wr_en      (w_wr_en[g]),
         .i_wr_val     (div_val),
         .o_pending    (div_pending[g]),
         .o_tick       (tick[g]),
         .o_clk_slow   (clk_slow[g])
      );
   end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Self-checking bench for clk_divider_multi. A main 4-channel instance is
// driven from a table of per-cycle stimulus with hand-derived expected
// outputs; a 3-channel instance exercises an out-of-range divisor select.
module tb_clk_divider_multi;

   localparam int W = 8;

   typedef struct {
      logic [3:0]   en;
      logic         sc;
      logic         we;
      logic [1:0]   sel;
      logic [W-1:0] val;
      logic         we3;
      logic         chk3;
      logic [3:0]   tick;
      logic [3:0]   slow;
      logic [3:0]   pend;
      logic [2:0]   tick3;
      logic [2:0]   slow3;
      logic [2:0]   pend3;
   } vec_t;

   typedef struct {
      int         row;
      logic       chk3;
      logic [3:0] tick;
      logic [3:0] slow;
      logic [3:0] pend;
      logic [2:0] tick3;
      logic [2:0] slow3;
      logic [2:0] pend3;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   en;
   logic         sync_clear;
   logic         div_we;
   logic         div_we3;
   logic [1:0]   div_sel;
   logic [W-1:0] div_val;
   logic [3:0]   div_pending, tick, clk_slow;
   logic [2:0]   div_pending3, tick3, clk_slow3;

   vec_t tbl[$];
   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   clk_divider_multi #(.WIDTH(W), .CHANNELS(4), .DEFAULT_DIV(5)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .sync_clear  (sync_clear),
      .div_we      (div_we),
      .div_sel     (div_sel),
      .div_val     (div_val),
      .div_pending (div_pending),
      .tick        (tick),
      .clk_slow    (clk_slow)
   );

   clk_divider_multi #(.WIDTH(W), .CHANNELS(3), .DEFAULT_DIV(5)) u_dut3 (
      .clk         (clk),
      .reset       (reset),
      .en          (en[2:0]),
      .sync_clear  (sync_clear),
      .div_we      (div_we3),
      .div_sel     (div_sel),
      .div_val     (div_val),
      .div_pending (div_pending3),
      .tick        (tick3),
      .clk_slow    (clk_slow3)
   );

   task automatic check(input string name, input int row, input logic [3:0] act,
                        input logic [3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
      end
   endtask

   function automatic vec_t v(input logic [3:0] e, input logic sc, input logic we,
                              input logic [1:0] sel, input logic [W-1:0] val,
                              input logic [3:0] t, input logic [3:0] s,
                              input logic [3:0] p);
      vec_t r;
      r.en = e;  r.sc = sc;  r.we = we;  r.sel = sel;  r.val = val;
      r.we3 = 1'b0;  r.chk3 = 1'b0;
      r.tick = t;  r.slow = s;  r.pend = p;
      r.tick3 = '0;  r.slow3 = '0;  r.pend3 = '0;
      return r;
   endfunction

   // Idle row: all channels enabled, no control activity.
   task automatic n(input logic [3:0] t, input logic [3:0] s, input logic [3:0] p);
      tbl.push_back(v(4'hF, 1'b0, 1'b0, 2'd0, '0, t, s, p));
   endtask

   // Row that also checks the 3-channel instance (divisor pending always 0).
   task automatic d(input logic [3:0] e, input logic we3, input logic [3:0] t,
                    input logic [3:0] s, input logic [2:0] t3, input logic [2:0] s3);
      vec_t r;
      r = v(e, 1'b0, 1'b0, we3 ? 2'd3 : 2'd0, we3 ? 8'd2 : 8'd0, t, s, 4'h0);
      r.we3 = we3;  r.chk3 = 1'b1;
      r.tick3 = t3;  r.slow3 = s3;  r.pend3 = 3'b000;
      tbl.push_back(r);
   endtask

   // Apply rows lo..hi-1; entered and left just after a falling edge.
   task automatic run_rows(input int lo, input int hi);
      exp_t e;
      exp_t g;
      for (int k = lo; k < hi; k++) begin
         en = tbl[k].en;  sync_clear = tbl[k].sc;  div_we = tbl[k].we;
         div_sel = tbl[k].sel;  div_val = tbl[k].val;  div_we3 = tbl[k].we3;
         e.row = k;  e.chk3 = tbl[k].chk3;
         e.tick = tbl[k].tick;  e.slow = tbl[k].slow;  e.pend = tbl[k].pend;
         e.tick3 = tbl[k].tick3;  e.slow3 = tbl[k].slow3;  e.pend3 = tbl[k].pend3;
         sb.push_back(e);
         @(posedge clk);
         #1;
         g = sb.pop_front();
         check("tick", g.row, tick, g.tick);
         check("clk_slow", g.row, clk_slow, g.slow);
         check("div_pending", g.row, div_pending, g.pend);
         if (g.chk3) begin
            check("tick3", g.row, {1'b0, tick3}, {1'b0, g.tick3});
            check("clk_slow3", g.row, {1'b0, clk_slow3}, {1'b0, g.slow3});
            check("div_pending3", g.row, {1'b0, div_pending3}, {1'b0, g.pend3});
         end
         @(negedge clk);
      end
      div_we = 1'b0;  div_we3 = 1'b0;  sync_clear = 1'b0;
   endtask

   initial begin
      int mark;
      // Default divisor 5: ticks at cycles 5,10,15; clk_slow high 5..9, 15.
      for (int i = 1; i <= 15; i++) begin
         n((i % 5 == 0) ? 4'hF : 4'h0, ((i / 5) % 2 == 1) ? 4'hF : 4'h0, 4'h0);
      end
      // Ch1 set to 8 by clear; write 3 at cycle 2, applied at cycle 8.
      tbl.push_back(v(4'hF, 1'b1, 1'b1, 2'd1, 8'd8, 4'h0, 4'h0, 4'h0));
      n(4'h0, 4'h0, 4'h0);
      tbl.push_back(v(4'hF, 1'b0, 1'b1, 2'd1, 8'd3, 4'h0, 4'h0, 4'h2));
      n(4'h0, 4'h0, 4'h2);  n(4'h0, 4'h0, 4'h2);
      n(4'hD, 4'hD, 4'h2);
      n(4'h0, 4'hD, 4'h2);  n(4'h0, 4'hD, 4'h2);
      n(4'h2, 4'hF, 4'h0);  n(4'h0, 4'hF, 4'h0);
      n(4'hD, 4'h2, 4'h0);  n(4'h2, 4'h0, 4'h0);
      n(4'h0, 4'h0, 4'h0);  n(4'h0, 4'h0, 4'h0);
      n(4'h2, 4'h2, 4'h0);  n(4'hD, 4'hF, 4'h0);
      n(4'h0, 4'hF, 4'h0);  n(4'h2, 4'hD, 4'h0);
      // Ch2 halted by divisor 0, then restarted with divisor 1.
      tbl.push_back(v(4'hF, 1'b1, 1'b1, 2'd1, 8'd5, 4'h0, 4'h0, 4'h0));
      tbl.push_back(v(4'hF, 1'b0, 1'b1, 2'd2, 8'd0, 4'h0, 4'h0, 4'h4));
      n(4'h0, 4'h0, 4'h4);  n(4'h0, 4'h0, 4'h4);  n(4'h0, 4'h0, 4'h4);
      n(4'hF, 4'hF, 4'h0);
      for (int i = 0; i < 4; i++) n(4'h0, 4'hF, 4'h0);
      n(4'hB, 4'h4, 4'h0);
      tbl.push_back(v(4'hF, 1'b0, 1'b1, 2'd2, 8'd1, 4'h0, 4'h4, 4'h4));
      n(4'h0, 4'h4, 4'h0);
      n(4'h4, 4'h0, 4'h0);  n(4'h4, 4'h4, 4'h0);
      n(4'hF, 4'hB, 4'h0);  n(4'h4, 4'hF, 4'h0);
      // Ch0 divisor 6 stalled for 4 cycles at cnt=2; out-of-range write on
      // the 3-channel instance during the stall.
      tbl.push_back(v(4'hF, 1'b1, 1'b1, 2'd2, 8'd5, 4'h0, 4'h0, 4'h0));
      tbl.push_back(v(4'hF, 1'b1, 1'b1, 2'd0, 8'd6, 4'h0, 4'h0, 4'h0));
      d(4'hF, 1'b0, 4'h0, 4'h0, 3'h0, 3'h0);
      d(4'hF, 1'b0, 4'h0, 4'h0, 3'h0, 3'h0);
      d(4'hE, 1'b0, 4'h0, 4'h0, 3'h0, 3'h0);
      d(4'hE, 1'b1, 4'h0, 4'h0, 3'h0, 3'h0);
      d(4'hE, 1'b0, 4'hE, 4'hE, 3'h6, 3'h6);
      d(4'hE, 1'b0, 4'h0, 4'hE, 3'h0, 3'h6);
      d(4'hF, 1'b0, 4'h0, 4'hE, 3'h0, 3'h6);
      d(4'hF, 1'b0, 4'h0, 4'hE, 3'h0, 3'h6);
      d(4'hF, 1'b0, 4'h0, 4'hE, 3'h1, 3'h7);
      d(4'hF, 1'b0, 4'hF, 4'h1, 3'h6, 3'h1);
      d(4'hF, 1'b0, 4'h0, 4'h1, 3'h0, 3'h1);
      d(4'hF, 1'b0, 4'h0, 4'h1, 3'h0, 3'h1);
      // Clear together with a write of 2 to ch3, then a pending write to ch1.
      tbl.push_back(v(4'hF, 1'b1, 1'b1, 2'd3, 8'd2, 4'h0, 4'h0, 4'h0));
      n(4'h0, 4'h0, 4'h0);  n(4'h8, 4'h8, 4'h0);  n(4'h0, 4'h8, 4'h0);
      n(4'h8, 4'h0, 4'h0);  n(4'h6, 4'h6, 4'h0);  n(4'h9, 4'hF, 4'h0);
      tbl.push_back(v(4'hF, 1'b0, 1'b1, 2'd1, 8'd4, 4'h0, 4'hF, 4'h2));
      mark = tbl.size();
      // After reset: write on ch1, then a second write on its terminal count.
      n(4'h0, 4'h0, 4'h0);
      tbl.push_back(v(4'hF, 1'b0, 1'b1, 2'd1, 8'd3, 4'h0, 4'h0, 4'h2));
      n(4'h0, 4'h0, 4'h2);  n(4'h0, 4'h0, 4'h2);
      tbl.push_back(v(4'hF, 1'b0, 1'b1, 2'd1, 8'd4, 4'hF, 4'hF, 4'h2));
      n(4'h0, 4'hF, 4'h2);  n(4'h0, 4'hF, 4'h2);
      n(4'h2, 4'hD, 4'h0);  n(4'h0, 4'hD, 4'h0);
      n(4'hD, 4'h0, 4'h0);  n(4'h0, 4'h0, 4'h0);  n(4'h2, 4'h2, 4'h0);

      // Outputs held at zero while reset is asserted, across clock edges.
      reset = 1'b0;  en = 4'hF;  sync_clear = 1'b0;  div_we = 1'b0;
      div_we3 = 1'b0;  div_sel = '0;  div_val = '0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check("rst_tick", -1, tick, 4'h0);
         check("rst_clk_slow", -1, clk_slow, 4'h0);
         check("rst_div_pending", -1, div_pending, 4'h0);
         check("rst_tick3", -1, {1'b0, tick3}, 4'h0);
      end
      @(negedge clk);
      reset = 1'b1;
      run_rows(0, mark);

      // Asynchronous reset between edges with clk_slow high and ch1 pending.
      #2;
      reset = 1'b0;
      #1;
      check("async_tick", -2, tick, 4'h0);
      check("async_clk_slow", -2, clk_slow, 4'h0);
      check("async_div_pending", -2, div_pending, 4'h0);
      @(negedge clk);
      reset = 1'b1;
      run_rows(mark, tbl.size());

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
